// File: rtl/id_stage_pipe_if.sv
// ---------------------------------------------------------------------------
// id_stage_pipe_if
//   Bundle of every non-clock/reset signal of the RV32I decode stage.
//   master : the surrounding pipeline (IF, WB, EX, hazard/flush control)
//   slave  : the decode stage itself
//   IF side  : if_valid, if_ready, if_instr, if_pc, if_pc4
//   WB side  : wb_we, wb_rd, wb_data
//   EX side  : ex_ready, flush, id_* registered ID/EX fields
//   Perf     : hazard_cnt, saturating count of load-use bubble cycles
// ---------------------------------------------------------------------------
interface id_stage_pipe_if #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int PERF_W     = 16
);
  logic                  if_valid;
  logic                  if_ready;
  logic [31:0]           if_instr;
  logic [XLEN-1:0]       if_pc;
  logic [XLEN-1:0]       if_pc4;
  logic                  wb_we;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic [XLEN-1:0]       wb_data;
  logic                  ex_ready;
  logic                  flush;
  logic                  id_valid;
  logic [XLEN-1:0]       id_pc;
  logic [XLEN-1:0]       id_pc4;
  logic [XLEN-1:0]       id_rs1_data;
  logic [XLEN-1:0]       id_rs2_data;
  logic [XLEN-1:0]       id_imm;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic [REG_ADDR_W-1:0] id_rd;
  logic [6:0]            id_opcode;
  logic [2:0]            id_funct3;
  logic                  id_funct7b5;
  logic                  id_reg_write;
  logic                  id_mem_read;
  logic                  id_mem_write;
  logic                  id_illegal;
  logic [PERF_W-1:0]     hazard_cnt;

  modport master (
    output if_valid, if_instr, if_pc, if_pc4, wb_we, wb_rd, wb_data,
           ex_ready, flush,
    input  if_ready, id_valid, id_pc, id_pc4, id_rs1_data, id_rs2_data,
           id_imm, id_rs1, id_rs2, id_rd, id_opcode, id_funct3, id_funct7b5,
           id_reg_write, id_mem_read, id_mem_write, id_illegal, hazard_cnt
  );

  modport slave (
    input  if_valid, if_instr, if_pc, if_pc4, wb_we, wb_rd, wb_data,
           ex_ready, flush,
    output if_ready, id_valid, id_pc, id_pc4, id_rs1_data, id_rs2_data,
           id_imm, id_rs1, id_rs2, id_rd, id_opcode, id_funct3, id_funct7b5,
           id_reg_write, id_mem_read, id_mem_write, id_illegal, hazard_cnt
  );
endinterface

// File: rtl/id_stage_pipe.sv
// ---------------------------------------------------------------------------
// id_stage_pipe
//   RV32I decode stage: register file with optional WB write-through bypass,
//   immediate generation, control decode, and a registered ID/EX stage with
//   valid/ready handshake, flush and load-use bubble insertion.
//   clk  : rising-edge clock
//   rst  : asynchronous, active-low reset
//   bus  : id_stage_pipe_if.slave (IF / WB / EX signals, see interface)
// ---------------------------------------------------------------------------
module id_stage_pipe #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter bit WB_BYPASS  = 1'b1,
  parameter int PERF_W     = 16
) (
  input  logic          clk,
  input  logic          rst,
  id_stage_pipe_if.slave bus
);
  localparam int NUM_REGS = 2**REG_ADDR_W;

  localparam logic [6:0] OP_I1  = 7'b0010011;
  localparam logic [6:0] OP_I2  = 7'b0000011;
  localparam logic [6:0] OP_S   = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_J   = 7'b1101111;
  localparam logic [6:0] OP_JR  = 7'b1100111;
  localparam logic [6:0] OP_U   = 7'b0110111;
  localparam logic [6:0] OP_UPC = 7'b0010111;

  // ---------------- register file ----------------
  logic [XLEN-1:0] r_regs [NUM_REGS];

  // NOTE: the register file is reset like any other state, so the loop
  // below is a reset of a memory; this keeps it in flops, not a RAM macro.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (bus.wb_we && (bus.wb_rd != '0)) begin
      r_regs[bus.wb_rd] <= bus.wb_data;
    end
  end

  logic [31:0]           w_instr;
  logic [6:0]            w_opcode;
  logic [REG_ADDR_W-1:0] w_rs1, w_rs2, w_rd;
  logic [XLEN-1:0]       w_rs1_data, w_rs2_data;

  assign w_instr  = bus.if_instr;
  assign w_opcode = w_instr[6:0];
  assign w_rs1    = REG_ADDR_W'(w_instr[19:15]);
  assign w_rs2    = REG_ADDR_W'(w_instr[24:20]);
  assign w_rd     = REG_ADDR_W'(w_instr[11:7]);

  // x0 reads 0 even when WB targets it; the bypass only forwards real writes.
  assign w_rs1_data = (w_rs1 == '0) ? '0 :
                      (WB_BYPASS && bus.wb_we && bus.wb_rd == w_rs1) ? bus.wb_data :
                      r_regs[w_rs1];
  assign w_rs2_data = (w_rs2 == '0) ? '0 :
                      (WB_BYPASS && bus.wb_we && bus.wb_rd == w_rs2) ? bus.wb_data :
                      r_regs[w_rs2];

  // ---------------- decode ----------------
  logic [31:0] w_imm32;
  logic        w_reg_write, w_mem_read, w_mem_write, w_illegal;
  logic        w_uses_rs1, w_uses_rs2;

  // NOTE: every output gets a default before the case so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    w_imm32     = '0;
    w_reg_write = 1'b0;
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_illegal   = 1'b0;
    w_uses_rs1  = 1'b0;
    w_uses_rs2  = 1'b0;
    unique case (w_opcode)
      OP_I1, OP_I2, OP_JR: begin
        w_imm32     = {{20{w_instr[31]}}, w_instr[31:20]};
        w_reg_write = 1'b1;
        w_mem_read  = (w_opcode == OP_I2);
        w_uses_rs1  = 1'b1;
      end
      OP_S: begin
        w_imm32     = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
        w_mem_write = 1'b1;
        w_uses_rs1  = 1'b1;
        w_uses_rs2  = 1'b1;
      end
      OP_R: begin
        w_reg_write = 1'b1;
        w_uses_rs1  = 1'b1;
        w_uses_rs2  = 1'b1;
      end
      OP_BR: begin
        w_imm32    = {{20{w_instr[31]}}, w_instr[7], w_instr[30:25],
                      w_instr[11:8], 1'b0};
        w_uses_rs1 = 1'b1;
        w_uses_rs2 = 1'b1;
      end
      OP_J: begin
        w_imm32     = {{12{w_instr[31]}}, w_instr[19:12], w_instr[20],
                       w_instr[30:21], 1'b0};
        w_reg_write = 1'b1;
      end
      OP_U, OP_UPC: begin
        w_imm32     = {w_instr[31:12], 12'b0};
        w_reg_write = 1'b1;
      end
      default: w_illegal = 1'b1;
    endcase
  end

  // ---------------- ID/EX register and handshake ----------------
  logic                  r_id_valid;
  logic [XLEN-1:0]       r_id_pc, r_id_pc4, r_id_rs1_data, r_id_rs2_data, r_id_imm;
  logic [REG_ADDR_W-1:0] r_id_rs1, r_id_rs2, r_id_rd;
  logic [6:0]            r_id_opcode;
  logic [2:0]            r_id_funct3;
  logic                  r_id_funct7b5, r_id_reg_write, r_id_mem_read;
  logic                  r_id_mem_write, r_id_illegal;
  logic [PERF_W-1:0]     r_hazard_cnt;
  logic                  w_advance, w_hazard;

  assign w_advance = !r_id_valid || bus.ex_ready;
  // Load in ID/EX whose destination is read by the instruction in decode.
  assign w_hazard  = r_id_valid && r_id_mem_read && (r_id_rd != '0) && bus.if_valid &&
                     ((w_uses_rs1 && w_rs1 == r_id_rd) || (w_uses_rs2 && w_rs2 == r_id_rd));
  // A flush consumes (and drops) the incoming instruction regardless of stalls.
  assign bus.if_ready = bus.flush || (w_advance && !w_hazard);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_id_valid     <= 1'b0;
      r_id_pc        <= '0;
      r_id_pc4       <= '0;
      r_id_rs1_data  <= '0;
      r_id_rs2_data  <= '0;
      r_id_imm       <= '0;
      r_id_rs1       <= '0;
      r_id_rs2       <= '0;
      r_id_rd        <= '0;
      r_id_opcode    <= '0;
      r_id_funct3    <= '0;
      r_id_funct7b5  <= 1'b0;
      r_id_reg_write <= 1'b0;
      r_id_mem_read  <= 1'b0;
      r_id_mem_write <= 1'b0;
      r_id_illegal   <= 1'b0;
      r_hazard_cnt   <= '0;
    end else if (bus.flush) begin
      r_id_valid <= 1'b0;
    end else if (!w_advance) begin
      // EX is stalled: hold every field.
    end else if (w_hazard) begin
      r_id_valid <= 1'b0;
      if (r_hazard_cnt != '1) r_hazard_cnt <= r_hazard_cnt + 1'b1;
    end else begin
      r_id_valid     <= bus.if_valid;
      r_id_pc        <= bus.if_pc;
      r_id_pc4       <= bus.if_pc4;
      r_id_rs1_data  <= w_rs1_data;
      r_id_rs2_data  <= w_rs2_data;
      r_id_imm       <= XLEN'($signed(w_imm32));
      r_id_rs1       <= w_rs1;
      r_id_rs2       <= w_rs2;
      r_id_rd        <= w_rd;
      r_id_opcode    <= w_opcode;
      r_id_funct3    <= w_instr[14:12];
      r_id_funct7b5  <= w_instr[30];
      r_id_reg_write <= w_reg_write;
      r_id_mem_read  <= w_mem_read;
      r_id_mem_write <= w_mem_write;
      r_id_illegal   <= w_illegal;
    end
  end

  assign bus.id_valid     = r_id_valid;
  assign bus.id_pc        = r_id_pc;
  assign bus.id_pc4       = r_id_pc4;
  assign bus.id_rs1_data  = r_id_rs1_data;
  assign bus.id_rs2_data  = r_id_rs2_data;
  assign bus.id_imm       = r_id_imm;
  assign bus.id_rs1       = r_id_rs1;
  assign bus.id_rs2       = r_id_rs2;
  assign bus.id_rd        = r_id_rd;
  assign bus.id_opcode    = r_id_opcode;
  assign bus.id_funct3    = r_id_funct3;
  assign bus.id_funct7b5  = r_id_funct7b5;
  assign bus.id_reg_write = r_id_reg_write;
  assign bus.id_mem_read  = r_id_mem_read;
  assign bus.id_mem_write = r_id_mem_write;
  assign bus.id_illegal   = r_id_illegal;
  assign bus.hazard_cnt   = r_hazard_cnt;
endmodule

// File: tb/tb_id_stage_pipe.sv
// ---------------------------------------------------------------------------
// tb_id_stage_pipe
//   Directed bench for id_stage_pipe. Two instances share the same stimulus:
//   u_dut_byp (WB_BYPASS=1) is the main target, u_dut_nob (WB_BYPASS=0) is
//   used where the bypass setting changes the captured operand.
// ---------------------------------------------------------------------------
module tb_id_stage_pipe;
  localparam int XLEN = 32;
  localparam int RAW  = 5;
  localparam int PW   = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            if_valid, wb_we, ex_ready, flush;
  logic [31:0]     if_instr;
  logic [XLEN-1:0] if_pc, if_pc4, wb_data;
  logic [RAW-1:0]  wb_rd;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  id_stage_pipe_if #(.XLEN(XLEN), .REG_ADDR_W(RAW), .PERF_W(PW)) u_if_byp ();
  id_stage_pipe_if #(.XLEN(XLEN), .REG_ADDR_W(RAW), .PERF_W(PW)) u_if_nob ();

  assign u_if_byp.if_valid = if_valid;  assign u_if_nob.if_valid = if_valid;
  assign u_if_byp.if_instr = if_instr;  assign u_if_nob.if_instr = if_instr;
  assign u_if_byp.if_pc    = if_pc;     assign u_if_nob.if_pc    = if_pc;
  assign u_if_byp.if_pc4   = if_pc4;    assign u_if_nob.if_pc4   = if_pc4;
  assign u_if_byp.wb_we    = wb_we;     assign u_if_nob.wb_we    = wb_we;
  assign u_if_byp.wb_rd    = wb_rd;     assign u_if_nob.wb_rd    = wb_rd;
  assign u_if_byp.wb_data  = wb_data;   assign u_if_nob.wb_data  = wb_data;
  assign u_if_byp.ex_ready = ex_ready;  assign u_if_nob.ex_ready = ex_ready;
  assign u_if_byp.flush    = flush;     assign u_if_nob.flush    = flush;

  id_stage_pipe #(.XLEN(XLEN), .REG_ADDR_W(RAW), .WB_BYPASS(1'b1), .PERF_W(PW))
    u_dut_byp (.clk(clk), .rst(rst), .bus(u_if_byp.slave));
  id_stage_pipe #(.XLEN(XLEN), .REG_ADDR_W(RAW), .WB_BYPASS(1'b0), .PERF_W(PW))
    u_dut_nob (.clk(clk), .rst(rst), .bus(u_if_nob.slave));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] instr, input logic [31:0] pc);
    if_valid = 1'b1;
    if_instr = instr;
    if_pc    = pc;
    if_pc4   = pc + 32'd4;
  endtask

  localparam logic [31:0] I_ADD_X6_X5  = 32'h0002_8333;
  localparam logic [31:0] I_ADDI_X8_X7 = 32'hFFF3_8413;
  localparam logic [31:0] I_LW_X1_X2   = 32'h0001_2083;
  localparam logic [31:0] I_ADD_X3_X1  = 32'h0010_81B3;
  localparam logic [31:0] I_LUI_X10    = 32'hABCD_E537;
  localparam logic [31:0] I_BEQ_M4     = 32'hFE00_0EE3;
  localparam logic [31:0] I_ADDI_X9_X0 = 32'h0050_0493;
  localparam logic [31:0] I_ILLEGAL    = 32'h0000_007F;

  initial begin
    rst = 1'b0; if_valid = 1'b0; if_instr = '0; if_pc = '0; if_pc4 = '0;
    wb_we = 1'b0; wb_rd = '0; wb_data = '0; ex_ready = 1'b1; flush = 1'b0;

    // Reset state
    #12;
    check("rst_id_valid",   32'(u_if_byp.id_valid),    32'd0);
    check("rst_hazard_cnt", 32'(u_if_byp.hazard_cnt),  32'd0);
    check("rst_rs1_data",   u_if_byp.id_rs1_data,      32'd0);
    check("rst_if_ready",   32'(u_if_byp.if_ready),    32'd1);
    rst = 1'b1;

    // WB writes x5, nothing from IF
    tick();
    wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEAD_BEEF;
    tick();
    check("idle_id_valid", 32'(u_if_byp.id_valid), 32'd0);

    // add x6,x5,x0: one-cycle latency, reads written x5
    wb_we = 1'b0;
    send(I_ADD_X6_X5, 32'h100);
    tick();
    check("add_valid",     32'(u_if_byp.id_valid),     32'd1);
    check("add_rs1_data",  u_if_byp.id_rs1_data,       32'hDEAD_BEEF);
    check("add_rs1_nob",   u_if_nob.id_rs1_data,       32'hDEAD_BEEF);
    check("add_rd",        32'(u_if_byp.id_rd),        32'd6);
    check("add_reg_write", 32'(u_if_byp.id_reg_write), 32'd1);
    check("add_pc",        u_if_byp.id_pc,             32'h100);
    check("add_pc4",       u_if_byp.id_pc4,            32'h104);

    // Same-cycle WB of x7 with decode of addi x8,x7,-1
    wb_we = 1'b1; wb_rd = 5'd7; wb_data = 32'h1234_5678;
    send(I_ADDI_X8_X7, 32'h104);
    tick();
    wb_we = 1'b0;
    check("byp_rs1_data", u_if_byp.id_rs1_data, 32'h1234_5678);
    check("byp_imm",      u_if_byp.id_imm,      32'hFFFF_FFFF);
    check("nob_rs1_data", u_if_nob.id_rs1_data, 32'h0);

    // Load-use: lw x1,0(x2) then add x3,x1,x1
    send(I_LW_X1_X2, 32'h108);
    tick();
    check("lw_mem_read", 32'(u_if_byp.id_mem_read), 32'd1);
    send(I_ADD_X3_X1, 32'h10C);
    #1;
    check("hz_if_ready", 32'(u_if_byp.if_ready), 32'd0);
    tick();
    check("hz_bubble_valid", 32'(u_if_byp.id_valid),   32'd0);
    check("hz_cnt_1",        32'(u_if_byp.hazard_cnt), 32'd1);
    check("hz_if_ready_rel", 32'(u_if_byp.if_ready),   32'd1);
    tick();
    check("hz_add_valid", 32'(u_if_byp.id_valid), 32'd1);
    check("hz_add_rd",    32'(u_if_byp.id_rd),    32'd3);
    check("hz_cnt_hold",  32'(u_if_byp.hazard_cnt), 32'd1);

    // EX stall for 3 cycles: fields hold, IF back-pressured
    ex_ready = 1'b0;
    send(I_LUI_X10, 32'h200);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_if_ready", 32'(u_if_byp.if_ready), 32'd0);
      tick();
      check("stall_valid", 32'(u_if_byp.id_valid), 32'd1);
      check("stall_rd",    32'(u_if_byp.id_rd),    32'd3);
      check("stall_pc",    u_if_byp.id_pc,         32'h10C);
      check("stall_op",    32'(u_if_byp.id_opcode), 32'h33);
    end
    ex_ready = 1'b1;
    tick();
    check("lui_rd",  32'(u_if_byp.id_rd), 32'd10);
    check("lui_imm", u_if_byp.id_imm,     32'hABCD_E000);
    check("lui_rw",  32'(u_if_byp.id_reg_write), 32'd1);

    // Flush with live ID/EX, incoming instr, and EX stalled
    ex_ready = 1'b0; flush = 1'b1;
    send(I_BEQ_M4, 32'h300);
    #1;
    check("flush_if_ready", 32'(u_if_byp.if_ready), 32'd1);
    tick();
    check("flush_valid", 32'(u_if_byp.id_valid), 32'd0);
    flush = 1'b0; ex_ready = 1'b1;

    // Writes to x0 never alter a read of 0
    wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFF_FFFF;
    send(I_ADDI_X9_X0, 32'h400);
    tick();
    check("x0_same_cycle", u_if_byp.id_rs1_data, 32'h0);
    wb_we = 1'b0;
    tick();
    check("x0_after_write", u_if_byp.id_rs1_data, 32'h0);
    check("addi_imm",       u_if_byp.id_imm,      32'd5);

    // Branch immediate
    send(I_BEQ_M4, 32'h404);
    tick();
    check("beq_imm", u_if_byp.id_imm,             32'hFFFF_FFFC);
    check("beq_rw",  32'(u_if_byp.id_reg_write),  32'd0);

    // Illegal opcode flows with valid=1
    send(I_ILLEGAL, 32'h408);
    tick();
    check("ill_valid",   32'(u_if_byp.id_valid),     32'd1);
    check("ill_illegal", 32'(u_if_byp.id_illegal),   32'd1);
    check("ill_rw",      32'(u_if_byp.id_reg_write), 32'd0);
    check("ill_imm",     u_if_byp.id_imm,            32'd0);

    // Flush beats hazard: no count increment
    send(I_LW_X1_X2, 32'h500);
    tick();
    flush = 1'b1;
    send(I_ADD_X3_X1, 32'h504);
    tick();
    flush = 1'b0;
    check("fh_valid", 32'(u_if_byp.id_valid),   32'd0);
    check("fh_cnt",   32'(u_if_byp.hazard_cnt), 32'd1);

    // Asynchronous reset mid-cycle
    send(I_ADD_X6_X5, 32'h600);
    tick();
    check("pre_rst_valid", 32'(u_if_byp.id_valid), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("arst_valid", 32'(u_if_byp.id_valid),   32'd0);
    check("arst_cnt",   32'(u_if_byp.hazard_cnt), 32'd0);
    #1 rst = 1'b1;
    tick();
    check("arst_rf_clear", u_if_byp.id_rs1_data, 32'h0);
    check("arst_reload",   32'(u_if_byp.id_valid), 32'd1);

    if_valid = 1'b0;
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Parametrised RV32I decode stage; sits between the IF stage and the EX stage.
- Contains the register file with WB write-through bypass, immediate generation and main control decode.
- Adds a registered ID/EX output with valid/ready handshake, flush, and load-use hazard bubble insertion.
- Adds a saturating hazard-stall performance counter.

Parameters:
XLEN, 32, datapath/register width
REG_ADDR_W, 5, register index width; NUM_REGS = 2**REG_ADDR_W
WB_BYPASS, 1, 1 = same-cycle WB write forwarded to decode read; 0 = read returns old value
PERF_W, 16, hazard counter width

Ports:
clk  in  1  rising-edge clock
rst  in  1  reset; asynchronous, active-low; one clock domain
if_valid  in  1  IF presents an instruction
if_ready  out  1  ID accepts the instruction this cycle
if_instr  in  32  instruction word
if_pc  in  XLEN  instruction PC
if_pc4  in  XLEN  PC+4
wb_we  in  1  writeback enable
wb_rd  in  REG_ADDR_W  writeback register
wb_data  in  XLEN  writeback data
ex_ready  in  1  EX can take the ID/EX register contents
flush  in  1  branch/jump redirect; kill the current and incoming instruction
id_valid  out  1  ID/EX register holds a live instruction
id_pc, id_pc4  out  XLEN  registered PC, PC+4
id_rs1_data, id_rs2_data  out  XLEN  registered operands
id_imm  out  XLEN  registered sign-extended immediate
id_rs1, id_rs2, id_rd  out  REG_ADDR_W  registered register indices
id_opcode  out  7  registered opcode
id_funct3  out  3  registered funct3
id_funct7b5  out  1  registered instr[30]
id_reg_write, id_mem_read, id_mem_write, id_illegal  out  1  registered controls
hazard_cnt  out  PERF_W  saturating count of bubble cycles

Behaviour:
Reset (rst=0, asynchronous):
- All registered outputs clear to 0, including id_valid=0 and hazard_cnt=0.
- All register-file entries clear to 0.
- Reset asserted mid-operation drops any in-flight instruction.

Register file:
- x0 always reads 0; writes to x0 are ignored.
- Write occurs at posedge when wb_we=1 and wb_rd!=0.
- Reads are combinational on if_instr[19:15] and if_instr[24:20].
- If WB_BYPASS=1, wb_we=1, wb_rd==rs and rs!=0, the read returns wb_data.

Decode (combinational from if_instr, opcode = instr[6:0]):
- Opcodes: I1=0010011, I2=0000011, S=0100011, R=0110011, BR=1100011, J=1101111, JR=1100111, U=0110111, UPC=0010111.
- Immediates:
  - I format for I1, I2, JR: sext instr[31:20].
  - S format: sext {instr[31:25], instr[11:7]}.
  - B format: sext {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U format for U, UPC: {instr[31:12], 12'b0}.
  - J format: sext {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - All other opcodes: imm = 0.
- reg_write = 1 for I1, I2, R, J, JR, U, UPC; mem_read = 1 for I2; mem_write = 1 for S.
- Any other opcode sets illegal=1 with all other controls 0; it still flows down the pipe with id_valid=1.
- uses_rs1 for I1, I2, S, R, BR, JR; uses_rs2 for S, R, BR.

Hazard:
- hazard = id_valid & id_mem_read & (id_rd!=0) & if_valid & ((uses_rs1 & rs1==id_rd) | (uses_rs2 & rs2==id_rd)).

Handshake:
- advance = !id_valid | ex_ready.
- if_ready = flush | (advance & !hazard).

Posedge priority:
1. flush: id_valid <= 0; the incoming instruction is consumed and dropped.
2. !advance: hold every ID/EX field unchanged.
3. hazard: insert a bubble (id_valid <= 0, other fields don't-care); if_instr is not consumed, so IF must hold it; hazard_cnt += 1, saturating at all-ones.
4. otherwise: id_valid <= if_valid; all fields load from decode and register-file reads.

Latency and other rules:
- Latency is 1 cycle from IF acceptance to id_valid.
- Throughput is 1 instruction/cycle with no hazard.
- A load-use pair costs exactly 1 bubble.
- WB write and decode read of the same register in the same cycle: with WB_BYPASS=1 the new value is captured; with WB_BYPASS=0 the old value is captured.
- flush together with hazard: flush wins and hazard_cnt is not incremented.
- flush together with !ex_ready: id_valid still clears.

Test Plan:
- Reset, then WB writes x5=0xDEADBEEF; next cycle IF sends add x6,x5,x0 (0x00028333) -> after 1 cycle id_valid=1, id_rs1_data=0xDEADBEEF, id_rd=6, id_reg_write=1.
- Same-cycle wb_we x7=0x12345678 with decode of addi x8,x7,-1 (0xFFF38413) -> WB_BYPASS=1 gives id_rs1_data=0x12345678, id_imm=0xFFFFFFFF; WB_BYPASS=0 gives id_rs1_data=0.
- lw x1,0(x2) followed by add x3,x1,x1, ex_ready=1 -> one cycle with if_ready=0 and id_valid=0; add issues the next cycle; hazard_cnt=1.
- ex_ready=0 for 3 cycles with id_valid=1 -> all id_* fields stable and if_ready=0; on ex_ready=1 the next instruction loads.
- flush=1 while id_valid=1 and if_valid=1 -> id_valid=0 next cycle and if_ready=1 that cycle; no write to x0 ever alters a read of 0.
- Decode coverage: beq with B-imm -4 (0xFE000EE3) gives id_imm=0xFFFFFFFC; lui 0xABCDE gives 0xABCDE000; opcode 0x7F gives id_illegal=1 and id_reg_write=0; rst pulled low mid-stream clears id_valid immediately, asynchronously.
